// File: rtl/maze_loader.sv
// Maze memory writer: accepts one maze row per valid/ready handshake and
// serialises it into single-bit writes on the shared loc/dIn/wr memory port.
module maze_loader #(
   parameter int ROWS  = 16,
   parameter int COLS  = 16,
   parameter int LOC_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [COLS-1:0]  rowIn,
   input  logic             rowValid,
   output logic             rowReady,
   output logic [LOC_W-1:0] loc,
   output logic             dOut,
   output logic             wr,
   output logic             busy,
   output logic             done,
   output logic             badMaze
);

   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_ROW,
      WRITE,
      DONE
   } state_t;

   state_t           state;
   logic [ROW_W-1:0] row_cnt;
   logic [COL_W-1:0] col_cnt;
   logic [COLS-1:0]  row_reg;
   logic             bad;
   logic             last_row;
   logic             last_col;
   logic             corner_cell;

   assign last_row    = (row_cnt == ROW_W'(ROWS - 1));
   assign last_col    = (col_cnt == COL_W'(COLS - 1));
   // Start (0,0) and goal (ROWS-1,COLS-1) must both be free for a solvable maze
   assign corner_cell = ((row_cnt == '0) && (col_cnt == '0)) || (last_row && last_col);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         row_cnt <= '0;
         col_cnt <= '0;
         row_reg <= '0;
         bad     <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state   <= WAIT_ROW;
                  row_cnt <= '0;
                  col_cnt <= '0;
                  bad     <= 1'b0;
               end
            end
            WAIT_ROW: begin
               if (rowValid) begin
                  row_reg <= rowIn;
                  col_cnt <= '0;
                  state   <= WRITE;
               end
            end
            WRITE: begin
               if (dOut && corner_cell)
                  bad <= 1'b1;
               if (last_col) begin
                  col_cnt <= '0;
                  if (last_row) begin
                     state <= DONE;
                  end else begin
                     row_cnt <= row_cnt + 1'b1;
                     state   <= WAIT_ROW;
                  end
               end else begin
                  col_cnt <= col_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rowReady = (state == WAIT_ROW);
   assign wr       = (state == WRITE);
   assign busy     = (state == WAIT_ROW) || (state == WRITE);
   assign done     = (state == DONE);
   assign badMaze  = bad;
   assign loc      = LOC_W'({row_cnt, col_cnt});
   assign dOut     = row_reg[col_cnt];

endmodule

// File: tb/tb_maze_loader.sv
// Self-checking bench for maze_loader: row-array reference model, randomized
// row contents and valid pacing, mid-load reset and ignored-start checks.
module tb_maze_loader;
   localparam int ROWS  = 16;
   localparam int COLS  = 16;
   localparam int LOC_W = 8;
   localparam int CELLS = ROWS * COLS;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [COLS-1:0]  rowIn;
   logic             rowValid;
   logic             rowReady;
   logic [LOC_W-1:0] loc;
   logic             dOut;
   logic             wr;
   logic             busy;
   logic             done;
   logic             badMaze;

   int errors = 0;
   int checks = 0;

   logic [COLS-1:0]  rows [ROWS];
   logic [CELLS-1:0] img;
   int               wr_n;

   maze_loader #(.ROWS(ROWS), .COLS(COLS), .LOC_W(LOC_W)) dut (
      .clk(clk), .rst(rst), .start(start), .rowIn(rowIn), .rowValid(rowValid),
      .rowReady(rowReady), .loc(loc), .dOut(dOut), .wr(wr), .busy(busy),
      .done(done), .badMaze(badMaze)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog observed=no_finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [CELLS-1:0] obs, input logic [CELLS-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected memory image: cell (r,c) lives at address r*COLS+c.
   function automatic logic [CELLS-1:0] image_of();
      logic [CELLS-1:0] v;
      v = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            v[r*COLS+c] = rows[r][c];
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_rows();
      for (int r = 0; r < ROWS; r++) rows[r] = '0;
   endtask

   task automatic random_rows();
      for (int r = 0; r < ROWS; r++) rows[r] = COLS'($urandom);
   endtask

   // One full load: rowValid high one cycle in every 'period'; optional start
   // pulse at write number poke_at; optional reset at write number abort_at.
   task automatic run_load(input int period, input int poke_at, input int abort_at);
      int acc = 0;
      int cyc = 0;
      int first_acc = -1;
      bit fin = 0;
      bit aborted = 0;
      wr_n = 0;
      img = '0;
      start = 1'b1;
      rowValid = 1'b0;
      step();
      start = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_ready", rowReady, 1);
      chk("start_done_clr", done, 0);
      chk("start_bad_clr", badMaze, 0);
      while (!fin && !aborted && cyc < 4000) begin
         if (wr) begin
            if (wr_n < CELLS) begin
               chk("loc_order", CELLS'(loc), CELLS'(wr_n));
               chk("dout", dOut, rows[wr_n / COLS][wr_n % COLS]);
            end else begin
               chk("extra_write", 1, 0);
            end
            chk("ready_in_write", rowReady, 0);
            img[loc] = dOut;
            if (wr_n == abort_at) rst = 1'b1;
            if (wr_n == poke_at) start = 1'b1;
            wr_n++;
         end
         if (done) begin
            fin = 1;
         end else begin
            rowValid = ((cyc % period) == period - 1);
            rowIn = (acc < ROWS) ? rows[acc] : COLS'($urandom);
            if (rowReady && rowValid) begin
               if (first_acc < 0) first_acc = cyc;
               acc++;
            end
            step();
            cyc++;
            start = 1'b0;
            if (rst) begin
               aborted = 1;
               chk("abort_wr", wr, 0);
               chk("abort_busy", busy, 0);
               chk("abort_done", done, 0);
               chk("abort_ready", rowReady, 0);
               rst = 1'b0;
               rowValid = 1'b0;
            end
         end
      end
      if (!aborted) begin
         chk("timeout", fin, 1);
         chk("write_count", CELLS'(wr_n), CELLS'(CELLS));
         if (period == 1)
            chk("done_latency", CELLS'(cyc - first_acc), CELLS'(ROWS * (COLS + 1)));
         chk("image", img, image_of());
         chk("bad_maze", badMaze, rows[0][0] | rows[ROWS-1][COLS-1]);
         rowValid = 1'b1;
         rowIn = '1;
         for (int i = 0; i < 3; i++) begin
            step();
            chk("done_hold", done, 1);
            chk("done_no_wr", wr, 0);
            chk("done_not_ready", rowReady, 0);
            chk("done_not_busy", busy, 0);
         end
         rowValid = 1'b0;
      end
   endtask

   initial begin
      logic [CELLS-1:0] row3_img;
      rst = 1'b1;
      start = 1'b0;
      rowValid = 1'b0;
      rowIn = '0;
      repeat (3) step();
      chk("rst_ready", rowReady, 0);
      chk("rst_wr", wr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_bad", badMaze, 0);
      chk("rst_loc", loc, 0);
      chk("rst_dout", dOut, 0);
      rst = 1'b0;
      rowValid = 1'b1;
      step();
      chk("idle_ignores_valid", busy, 0);
      rowValid = 1'b0;

      clear_rows();
      run_load(1, -1, -1);

      rows[3] = 16'h8001;
      run_load(1, -1, -1);
      row3_img = '0;
      row3_img[8'h30] = 1'b1;
      row3_img[8'h3F] = 1'b1;
      chk("row3_image", img, row3_img);

      clear_rows();
      rows[0] = 16'h0001;
      run_load(1, -1, -1);
      chk("bad_start_cell", badMaze, 1);

      clear_rows();
      rows[ROWS-1] = 16'h8000;
      run_load(1, -1, -1);
      chk("bad_goal_cell", badMaze, 1);

      random_rows();
      run_load(5, 40, -1);

      random_rows();
      run_load(1, -1, 7 * COLS + 5);
      chk("abort_partial", CELLS'(wr_n), CELLS'(7 * COLS + 6));
      step();
      chk("abort_idle", busy, 0);

      random_rows();
      run_load(1, -1, -1);

      for (int k = 0; k < 2; k++) begin
         random_rows();
         run_load(int'($urandom_range(1, 4)), int'($urandom_range(0, CELLS - 1)), -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/maze_loader.md
Name: maze_loader

Overview:
Writer side of the maze memory interface: fills the 1-bit-per-cell maze memory that the rat solver later reads. Accepts the maze one row at a time over a valid/ready handshake. Each row is serialised into single-bit memory writes, one cell per clock. Sits beside the solver on the memory's loc/dIn/wr port; the solver is started only after done is asserted.

Parameters:
ROWS, 16, number of maze rows (row index stored in loc[7:4])
COLS, 16, number of maze columns and width of one row word (column index stored in loc[3:0])
LOC_W, 8, memory address width; loc = {row[3:0], col[3:0]}

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a new load; sampled only in IDLE or DONE
rowIn  input  COLS  one maze row; bit c = cell (row, c); 1 = wall, 0 = free
rowValid  input  1  rowIn holds a valid row
rowReady  output  1  loader can accept a row this cycle
loc  output  LOC_W  memory address {rowCnt, colCnt}
dOut  output  1  data bit to memory (rowReg[colCnt])
wr  output  1  memory write strobe, one cell per asserted cycle
busy  output  1  load in progress (WAIT_ROW or WRITE)
done  output  1  all ROWS*COLS cells written; level, held in DONE
badMaze  output  1  valid in DONE: wall at start cell (0,0) or goal cell (ROWS-1,COLS-1)

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, rowCnt=0, colCnt=0, rowReg=0, badMaze=0. Outputs after reset: rowReady=0, wr=0, busy=0, done=0, badMaze=0, loc=0, dOut=0.
- Reset asserted mid-load aborts at the next edge: no further wr pulses, memory contents left partial, done stays 0.
- States:
  - IDLE: start=1 -> WAIT_ROW; rowCnt=0; colCnt=0; badMaze=0.
  - WAIT_ROW: rowReady=1. On rowValid&rowReady: rowReg<=rowIn -> WRITE, colCnt=0. rowValid=0 -> stay; no timeout.
  - WRITE: wr=1, loc={rowCnt,colCnt}, dOut=rowReg[colCnt]. All three are combinational from state and counters. colCnt increments each cycle.
    - At colCnt=COLS-1: if rowCnt=ROWS-1 -> DONE, else rowCnt++ and -> WAIT_ROW.
    - badMaze set (sticky) when writing (0,0) with dOut=1, or (ROWS-1,COLS-1) with dOut=1.
  - DONE: done=1, rowReady=0, wr=0. start=1 -> WAIT_ROW, clearing done, badMaze and counters.
- busy=1 exactly in WAIT_ROW and WRITE.
- start is ignored in WAIT_ROW and WRITE; it does not restart the load.
- rowReady=0 in WRITE. Rows are never dropped or overwritten: rowIn/rowValid are ignored while writing.
- Latency per row: 1 accept cycle + COLS write cycles. With rowValid held high, a full load takes ROWS*(COLS+1) cycles from the first accept; done rises on the edge after the final write (272 cycles for 16x16).
- Counters wrap only through the explicit state transitions above. loc never exceeds ROWS*COLS-1.

Test Plan:
- Reset then start, rowValid held high, rowIn=16'h0000 for all rows -> exactly 256 wr pulses with loc 0..255 in order, all dOut=0; done=1 at cycle 272 after first accept; badMaze=0.
- Row 3 = 16'h8001, others 0 -> dOut=1 only at loc 8'h30 and 8'h3F.
- Row 0 = 16'h0001 -> after load, done=1 and badMaze=1. Separately, row 15 = 16'h8000 -> badMaze=1.
- rowValid toggled (valid one cycle in every 5) -> no wr while in WAIT_ROW; rowReady=0 throughout each 16-cycle WRITE burst; final memory image identical to the always-valid case.
- rst=1 during WRITE of row 7, col 5 -> next cycle wr=0, busy=0, done=0, state IDLE. A new start then reloads from loc 0.
- start pulsed during WRITE -> ignored, load unaffected. start in DONE -> done drops next cycle, rowReady=1, second load begins at loc 0.
